// File: rtl/imem_dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter_pkg
//  Purpose  : Shared encodings for the instruction/data memory arbiter.
//             The FSM state and grant-select encodings are also used by the
//             core's hazard/stall logic.
//  Revision : 1.0 - initial release
// ============================================================================
package imem_dmem_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_WAIT_D = 2'd1,
        ARB_WAIT_I = 2'd2
    } arb_state_e;

    // Which requester owns the memory port in the issue cycle.
    typedef enum logic [0:0] {
        ARB_SEL_D = 1'b0,
        ARB_SEL_I = 1'b1
    } arb_sel_e;

endpackage : imem_dmem_arbiter_pkg
`default_nettype wire

// File: rtl/imem_dmem_arbiter_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module   : arb_starve_ctr
//  Purpose  : Counts consecutive data grants taken while a fetch was waiting
//             and raises a fetch-priority override once the count saturates.
//             Instantiated by the arbiter only when ARB_STARVE_GUARD_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic data_acc_i,    // data grant accepted by memory this cycle
    input  logic fetch_acc_i,   // fetch grant accepted by memory this cycle
    input  logic fetch_wait_i,  // if_req & ~flush
    input  logic if_req_i,
    output logic fetch_prio_o
);
    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear when fetch is served or stops asking, else saturate-increment.
    always_comb begin
        cnt_d = cnt_q;
        if (fetch_acc_i || !if_req_i) begin
            cnt_d = '0;
        end else if (data_acc_i && fetch_wait_i && (cnt_q != C_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_prio_o = (cnt_q == C_LIMIT);

endmodule : arb_starve_ctr
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_dmem_arbiter
//  Purpose  : Shares one single-ported variable-latency memory port between
//             instruction fetch and the load/store stage. One transaction in
//             flight, data has priority, flushed fetch responses are dropped.
//  Options  : ARB_STARVE_GUARD_EN - lets a waiting fetch win after
//             STARVE_LIMIT consecutive data grants.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    // fetch side
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                flush,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_busy,
    // data side
    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_busy,
    // memory port
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int BE_W = DATA_W / 8;

    arb_state_e state_q, state_d;
    logic       kill_q,  kill_d;

    logic       w_fetch_ok;
    logic       w_fetch_prio;
    logic       w_accept;
    arb_sel_e   w_sel;

    assign w_fetch_ok = if_req && !flush;

`ifdef ARB_STARVE_GUARD_EN
    logic w_data_acc;
    logic w_fetch_acc;

    assign w_data_acc  = w_accept && (w_sel == ARB_SEL_D);
    assign w_fetch_acc = w_accept && (w_sel == ARB_SEL_I);

    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk          (clk),
        .rst          (rst),
        .data_acc_i   (w_data_acc),
        .fetch_acc_i  (w_fetch_acc),
        .fetch_wait_i (w_fetch_ok),
        .if_req_i     (if_req),
        .fetch_prio_o (w_fetch_prio)
    );
`else
    assign w_fetch_prio = 1'b0;
`endif

    // Grant select: data first unless no data request or the starve guard overrides.
    always_comb begin
        w_sel = ARB_SEL_D;
        if (w_fetch_ok && (!d_req || w_fetch_prio)) begin
            w_sel = ARB_SEL_I;
        end
    end

    // Port mux; only the IDLE state may request.
    assign mem_req   = (state_q == ARB_IDLE) && (d_req || w_fetch_ok);
    assign mem_addr  = (w_sel == ARB_SEL_I) ? if_addr : d_addr;
    assign mem_we    = (w_sel == ARB_SEL_I) ? {BE_W{1'b0}} : d_we;
    assign mem_wdata = d_wdata;
    assign w_accept  = mem_req && mem_ready;

    // Read data is passed straight through; the strobes qualify it.
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    // Next-state and completion strobes.
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        if_rvalid = 1'b0;
        d_ack     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (w_accept) begin
                    if (w_sel == ARB_SEL_I) begin
                        state_d = ARB_WAIT_I;
                        kill_d  = flush;
                    end else if (d_we != {BE_W{1'b0}}) begin
                        d_ack = 1'b1;          // writes complete on acceptance
                    end else begin
                        state_d = ARB_WAIT_D;
                    end
                end
            end
            ARB_WAIT_D: begin
                if (mem_rvalid) begin
                    d_ack   = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            ARB_WAIT_I: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (mem_rvalid) begin
                    if_rvalid = !kill_q && !flush;
                    state_d   = ARB_IDLE;
                    kill_d    = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // State and kill registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    assign if_busy = if_req && !if_rvalid;
    assign d_busy  = d_req && !d_ack;

endmodule : imem_dmem_arbiter
`default_nettype wire
